// File: rtl/data_mem_interface.sv
// Data-memory bus adapter between the memory stage and a valid/ready memory port.
// One outstanding transaction at a time; optional abort-on-timeout under `MEM_TIMEOUT_EN`.
module data_mem_interface #(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [3:0]           mask,
    input  logic [DataWidth-1:0] address,
    input  logic [DataWidth-1:0] store_data,
    output logic                 stall,
    output logic                 data_valid,
    output logic [DataWidth-1:0] load_data_out,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_rvalid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic                 mem_valid_q;
    logic                 mem_we_q;
    logic [DataWidth-1:0] mem_addr_q;
    logic [DataWidth-1:0] mem_wdata_q;
    logic [3:0]           mem_wstrb_q;
    logic [DataWidth-1:0] load_data_q;
    logic                 expire;
    logic                 abort;
    logic                 unused_addr_lsbs;

    // Bus is word addressed; the byte offset is already folded into mask.
    assign unused_addr_lsbs = ^address[1:0];

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (request) state_d = REQ;
            REQ: begin
                if (mem_valid_q && mem_ready) begin
                    state_d = mem_we_q ? DONE : WAIT;
                end else if (expire) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                end else if (expire) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= (state_d == REQ);
            if (state_q == IDLE && request) begin
                mem_addr_q  <= {address[DataWidth-1:2], 2'b00};
                mem_wdata_q <= store_data;
                mem_we_q    <= we_re;
                mem_wstrb_q <= we_re ? mask : 4'b0000;
            end
            // A response on the expiry cycle wins over the abort.
            if (state_q == WAIT && mem_rvalid) begin
                load_data_q <= mem_rdata;
            end else if (abort) begin
                load_data_q <= '0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry on the TimeoutCycles-th cycle spent in REQ/WAIT.
    assign expire = (state_q == REQ || state_q == WAIT) &&
                    (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end

    assign bus_error = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TimeoutCycles > 0);
    assign expire         = 1'b0;
    assign bus_error      = 1'b0;
`endif

    assign stall = (state_q == IDLE && request) || state_q == REQ || state_q == WAIT;
    assign data_valid    = (state_q == DONE);
    assign load_data_out = load_data_q;
    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// Bench for data_mem_interface: directed table, random transactions against a
// latency/payload model, and hand sequences for back-to-back, reset and timeout.
module tb_data_mem_interface;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request = 1'b0;
    logic          we_re = 1'b0;
    logic [3:0]    mask = '0;
    logic [DW-1:0] address = '0;
    logic [DW-1:0] store_data = '0;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall, data_valid, mem_valid, mem_we, bus_error;
    logic [DW-1:0] load_data_out, mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;

    data_mem_interface #(.DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data), .stall(stall),
        .data_valid(data_valid), .load_data_out(load_data_out),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_load = '0;

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [3:0]    mask;
        logic [DW-1:0] wdata;
        int            d;      // cycles of backpressure before ready
        int            v;      // cycles from accept to rvalid (loads)
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_addr;
        logic [3:0]    exp_wstrb;
        int            exp_lat; // cycle index of data_valid, request seen at 0
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the bus should see and when completion occurs.
    function automatic vec_t model(input logic we, input logic [DW-1:0] addr, input logic [3:0] m,
                                   input logic [DW-1:0] wd, input int d, input int v,
                                   input logic [DW-1:0] rd);
        vec_t t;
        t.we = we; t.addr = addr; t.mask = m; t.wdata = wd; t.d = d; t.v = v; t.rdata = rd;
        t.exp_addr  = addr & 32'hFFFF_FFFC;
        t.exp_wstrb = we ? m : 4'b0000;
        t.exp_lat   = we ? 2 + d : 2 + d + v;
        return t;
    endfunction

    task automatic run_txn(input vec_t t);
        int hs;
        int rv;
        hs = 1 + t.d;
        rv = hs + t.v;
        step();
        request = 1'b1; we_re = t.we; address = t.addr; mask = t.mask; store_data = t.wdata;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("c0 stall", stall, 1);
        chk("c0 mem_valid", mem_valid, 0);
        chk("c0 data_valid", data_valid, 0);
        for (int c = 1; c <= t.exp_lat + 1; c++) begin
            step();
            request = 1'b0; we_re = 1'($urandom); mask = 4'($urandom);
            address = $urandom; store_data = $urandom;
            mem_ready = (c >= hs);
            mem_rdata = $urandom;
            if (t.we || c <= hs || c > rv) mem_rvalid = 1'($urandom);
            else mem_rvalid = 1'b0;
            if (!t.we && c == rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = t.rdata;
            end
            @(negedge clk);
            chk("mem_valid", mem_valid, (c <= hs));
            if (c <= hs) begin
                chk("mem_addr", mem_addr, t.exp_addr);
                chk("mem_wdata", mem_wdata, t.wdata);
                chk("mem_wstrb", mem_wstrb, t.exp_wstrb);
                chk("mem_we", mem_we, t.we);
            end
            chk("stall", stall, (c < t.exp_lat));
            chk("data_valid", data_valid, (c == t.exp_lat));
            chk("bus_error", bus_error, 0);
            if (c == t.exp_lat && !t.we) last_load = t.rdata;
            if (c >= t.exp_lat) chk("load_data_out", load_data_out, last_load);
        end
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0106, 4'b1100, 32'hABCD_0000, 0, 1, 32'h0,
                    32'h0000_0104, 4'b1100, 2};
        vecs[1] = '{1'b0, 32'h0000_2003, 4'b1111, 32'h5555_AAAA, 3, 2, 32'hDEAD_BEEF,
                    32'h0000_2000, 4'b0000, 7};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 4'b0011, 32'h0, 0, 1, 32'h0BAD_F00D,
                    32'hFFFF_FFFC, 4'b0000, 3};
        vecs[3] = '{1'b1, 32'h1000_0001, 4'b0001, 32'h0000_00EE, 5, 1, 32'h0,
                    32'h1000_0000, 4'b0001, 7};

        // Reset values
        address = 32'h1234_5678; store_data = 32'h9ABC_DEF0;
        #2;
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst data_valid", data_valid, 0);
        chk("rst bus_error", bus_error, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_wstrb", mem_wstrb, 0);
        chk("rst load_data_out", load_data_out, 0);
        chk("rst stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            run_txn(model(1'($urandom), $urandom, 4'($urandom), $urandom,
                          $urandom_range(0, 3), $urandom_range(1, 4), $urandom));
        end

        // Back-to-back: load then store with request held high throughout.
        begin
            int n_hs;
            n_hs = 0;
            step();
            request = 1'b1; we_re = 1'b0; address = 32'h0000_0A0A; mask = 4'b1111;
            store_data = 32'h1111_2222; mem_ready = 1'b1; mem_rvalid = 1'b0;
            @(negedge clk);
            chk("b2b c0 stall", stall, 1);
            for (int c = 1; c <= 7; c++) begin
                step();
                if (c == 1) begin
                    we_re = 1'b1; address = 32'h0000_0B0B; mask = 4'b0011;
                    store_data = 32'h3333_4444;
                end
                if (c == 5) request = 1'b0;
                mem_rvalid = (c == 2);
                mem_rdata  = (c == 2) ? 32'hFEED_FACE : $urandom;
                @(negedge clk);
                if (mem_valid && mem_ready) n_hs++;
                chk("b2b mem_valid", mem_valid, (c == 1 || c == 5));
                chk("b2b data_valid", data_valid, (c == 3 || c == 6));
                chk("b2b stall", stall, (c == 1 || c == 2 || c == 4 || c == 5));
                if (c == 1) begin
                    chk("b2b ld addr", mem_addr, 32'h0000_0A08);
                    chk("b2b ld we", mem_we, 0);
                end
                if (c == 3) chk("b2b ld data", load_data_out, 32'hFEED_FACE);
                if (c == 5) begin
                    chk("b2b st addr", mem_addr, 32'h0000_0B08);
                    chk("b2b st we", mem_we, 1);
                    chk("b2b st wstrb", mem_wstrb, 4'b0011);
                    chk("b2b st wdata", mem_wdata, 32'h3333_4444);
                end
            end
            chk("b2b handshakes", n_hs, 2);
            last_load = 32'hFEED_FACE;
            step();
            mem_ready = 1'b0; mem_rvalid = 1'b0;
        end

        // Async reset while waiting for read data.
        step();
        request = 1'b1; we_re = 1'b0; address = 32'h0000_0044; store_data = 32'h7777_7777;
        step();
        request = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("pre-rst stall", stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst mem_valid", mem_valid, 0);
        chk("arst mem_addr", mem_addr, 0);
        chk("arst mem_wdata", mem_wdata, 0);
        chk("arst load_data_out", load_data_out, 0);
        chk("arst data_valid", data_valid, 0);
        chk("arst stall", stall, 0);
        last_load = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            mem_rvalid = (c == 0);
            mem_rdata  = 32'h1234_5678;
            @(negedge clk);
            chk("late rvalid data_valid", data_valid, 0);
            chk("late rvalid stall", stall, 0);
            chk("late rvalid load_data_out", load_data_out, 0);
        end
        step();
        mem_rvalid = 1'b0;

`ifdef MEM_TIMEOUT_EN
        run_txn(model(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 0, 1, 32'hCAFE_F00D));
        // mem_ready never comes: abort after TO cycles in REQ.
        step();
        request = 1'b1; we_re = 1'b0; address = 32'h0000_0500;
        for (int c = 1; c <= TO + 2; c++) begin
            step();
            request = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
            @(negedge clk);
            chk("to mem_valid", mem_valid, (c <= TO));
            chk("to data_valid", data_valid, (c == TO + 1));
            chk("to bus_error", bus_error, (c == TO + 1));
            chk("to stall", stall, (c <= TO));
            if (c >= TO + 1) chk("to load_data_out", load_data_out, 0);
        end
        last_load = '0;
        // Response / handshake landing exactly on the expiry cycle completes normally.
        run_txn(model(1'b0, 32'h0000_0600, 4'b0000, 32'h0, 0, TO - 1, 32'h600D_DA7A));
        run_txn(model(1'b1, 32'h0000_0700, 4'b1010, 32'h5A5A_5A5A, TO - 1, 1, 32'h0));
`else
        // Without the timeout, a long stall simply waits.
        run_txn(model(1'b1, 32'h0000_0800, 4'b1111, 32'h0F0F_0F0F, 12, 1, 32'h0));
        run_txn(model(1'b0, 32'h0000_0900, 4'b0000, 32'h0, 2, 12, 32'hA5A5_5A5A));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
